// File: rtl/uart_pkg.sv
// Definitions shared by the UART receive and transmit blocks: state encoding,
// default framing parameters and the packet-memory address map.
package uart_pkg;

    localparam int OVS_DEF   = 8;
    localparam int BYTES_DEF = 4;
    localparam int ADDR_W    = 9;
    localparam int CYCLE_W   = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } rx_state_t;

    // Packet memory address: byte_idx + (cycle << 2); the TX side reads with the same map.
    function automatic logic [ADDR_W-1:0] pkt_addr(input logic [1:0]         byte_idx,
                                                   input logic [CYCLE_W-1:0] cycle);
        return {2'b00, cycle, byte_idx};
    endfunction

endpackage

// File: rtl/uart_rx_frame_if.sv
// Write port from the UART receiver into the packet memory, plus packet status.
interface uart_rx_frame_if;
    import uart_pkg::*;

    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [7:0]         wr_data;
    logic [CYCLE_W-1:0] cycle;
    logic               pkt_done;
    logic               frame_err;

    modport master (output wr_en, wr_addr, wr_data, cycle, pkt_done, frame_err);
    modport slave  (input  wr_en, wr_addr, wr_data, cycle, pkt_done, frame_err);

endinterface

// File: rtl/uart_rx_bit.sv
// Oversampling bit receiver: synchronises rx and assembles one 8N1 character,
// reporting the byte and its stop-bit quality for one cycle at the stop sample.
module uart_rx_bit import uart_pkg::*; #(
    parameter int OVS = OVS_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       valid,
    output logic       stop_ok,
    output logic       idle
);

    localparam logic [3:0] TICK_MID = 4'(OVS / 2 - 1);
    localparam logic [3:0] TICK_END = 4'(OVS - 1);

    logic       rx_meta, rxs;
    rx_state_t  state, state_nx;
    logic [3:0] tick, tick_nx;
    logic [2:0] bitcnt, bitcnt_nx;
    logic [7:0] shreg, shreg_nx;
    logic       armed, armed_nx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            state   <= ST_IDLE;
            tick    <= 4'd0;
            bitcnt  <= 3'd0;
            shreg   <= 8'd0;
            armed   <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
            state   <= state_nx;
            tick    <= tick_nx;
            bitcnt  <= bitcnt_nx;
            shreg   <= shreg_nx;
            armed   <= armed_nx;
        end
    end

    // A bad stop bit disarms start detection until the line has been seen high,
    // so a held break produces a single framing error.
    always_comb begin
        state_nx  = state;
        tick_nx   = tick + 4'd1;
        bitcnt_nx = bitcnt;
        shreg_nx  = shreg;
        armed_nx  = armed;
        valid     = 1'b0;
        stop_ok   = 1'b0;
        case (state)
            ST_IDLE: begin
                tick_nx = 4'd0;
                if (rxs) begin
                    armed_nx = 1'b1;
                end else if (armed) begin
                    state_nx = ST_START;
                end
            end
            ST_START: begin
                if (tick == TICK_MID) begin
                    tick_nx   = 4'd0;
                    bitcnt_nx = 3'd0;
                    state_nx  = rxs ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick == TICK_END) begin
                    tick_nx   = 4'd0;
                    shreg_nx  = {rxs, shreg[7:1]};
                    bitcnt_nx = bitcnt + 3'd1;
                    if (bitcnt == 3'd7) begin
                        state_nx = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (tick == TICK_END) begin
                    tick_nx  = 4'd0;
                    valid    = 1'b1;
                    stop_ok  = rxs;
                    armed_nx = rxs;
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign rx_byte = shreg;
    assign idle    = (state == ST_IDLE);

endmodule

// File: rtl/uart_rx_frame.sv
// UART packet receiver: groups received bytes into fixed-size packets and writes
// them to slot-indexed packet memory, aborting partial packets on framing errors or long gaps.
module uart_rx_frame import uart_pkg::*; #(
    parameter int OVS      = OVS_DEF,
    parameter int BYTES    = BYTES_DEF,
    parameter int GAP_BITS = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    uart_rx_frame_if.master   wr
);

    localparam int               GAP_LIMIT = GAP_BITS * OVS;
    localparam int               GAP_W     = $clog2(GAP_LIMIT + 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_LIMIT - 1);
    localparam logic [1:0]       LAST_IDX  = 2'(BYTES - 1);

    logic [7:0]       rx_byte;
    logic             byte_valid, stop_ok, bit_idle;
    logic [1:0]       byte_idx;
    logic [GAP_W-1:0] gap_cnt;
    logic             gap_hit;

    uart_rx_bit #(.OVS(OVS)) u_bit (
        .clk     (clk),
        .reset   (reset),
        .rx      (rx),
        .rx_byte (rx_byte),
        .valid   (byte_valid),
        .stop_ok (stop_ok),
        .idle    (bit_idle)
    );

    // The gap abort is evaluated before a start edge in the same cycle can matter,
    // so a byte starting right at the limit becomes byte 0 of a fresh packet.
    assign gap_hit = bit_idle && (byte_idx != 2'd0) && (gap_cnt == GAP_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_idx     <= 2'd0;
            gap_cnt      <= '0;
            wr.wr_en     <= 1'b0;
            wr.wr_addr   <= '0;
            wr.wr_data   <= 8'd0;
            wr.cycle     <= '0;
            wr.pkt_done  <= 1'b0;
            wr.frame_err <= 1'b0;
        end else begin
            wr.wr_en     <= 1'b0;
            wr.pkt_done  <= 1'b0;
            wr.frame_err <= 1'b0;

            if (bit_idle && (byte_idx != 2'd0) && !gap_hit) begin
                gap_cnt <= gap_cnt + GAP_W'(1);
            end else begin
                gap_cnt <= '0;
            end

            if (gap_hit) begin
                byte_idx     <= 2'd0;
                wr.frame_err <= 1'b1;
            end else if (byte_valid) begin
                if (stop_ok) begin
                    wr.wr_en   <= 1'b1;
                    wr.wr_data <= rx_byte;
                    wr.wr_addr <= pkt_addr(byte_idx, wr.cycle);
                    if (byte_idx == LAST_IDX) begin
                        wr.pkt_done <= 1'b1;
                        byte_idx    <= 2'd0;
                        wr.cycle    <= wr.cycle + CYCLE_W'(1);
                    end else begin
                        byte_idx <= byte_idx + 2'd1;
                    end
                end else begin
                    byte_idx     <= 2'd0;
                    wr.frame_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: serialises directed 8N1 frames and scores every output
// cycle against a packet-level model of the expected memory writes and errors.
module tb_uart_rx_frame;
    import uart_pkg::*;

    localparam int OVS      = 8;
    localparam int BYTES    = 4;
    localparam int GAP_BITS = 12;
    localparam int GAP_CYC  = GAP_BITS * OVS;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic rx    = 1'b1;

    uart_rx_frame_if wr();

    uart_rx_frame #(.OVS(OVS), .BYTES(BYTES), .GAP_BITS(GAP_BITS)) dut (
        .clk   (clk),
        .reset (reset),
        .rx    (rx),
        .wr    (wr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
        bit last;
        int cyc_after;
    } wr_exp_t;

    wr_exp_t exp_q[$];
    int      log_addr[$];
    int      log_data[$];
    int total = 0, bad = 0;
    int m_idx = 0, m_cyc = 0;
    int exp_err = 0, exp_addr = 0, exp_data = 0, exp_cyc = 0;
    int cyc_no = 0, last_wr_cyc = 0, last_err_cyc = 0, n_wr = 0, n_err = 0;
    bit prev_wr = 0, prev_done = 0, prev_err = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t",
                     name, actual, actual, expected, expected, $time);
        end
    endtask

    // Packet-level model: where each good byte must land and which events raise frame_err.
    task automatic model_byte(input int data, input bit stop_bit);
        wr_exp_t e;
        if (stop_bit) begin
            e.addr = m_idx + 4 * m_cyc;
            e.data = data;
            e.last = (m_idx == BYTES - 1);
            if (e.last) begin
                m_idx = 0;
                m_cyc = (m_cyc + 1) % 32;
            end else begin
                m_idx++;
            end
            e.cyc_after = m_cyc;
            exp_q.push_back(e);
        end else begin
            exp_err++;
            m_idx = 0;
        end
    endtask

    task automatic model_gap();
        if (m_idx != 0) begin
            exp_err++;
            m_idx = 0;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_idx = 0; m_cyc = 0;
        exp_err = 0; exp_addr = 0; exp_data = 0; exp_cyc = 0;
    endtask

    // All stimulus tasks start and end one time unit after a rising edge.
    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit);
        logic [9:0] f;
        model_byte(int'(data), stop_bit);
        f = {stop_bit, data, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            repeat (OVS) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_partial(input logic [7:0] data, input int nbits);
        logic [8:0] f;
        f = {data, 1'b0};
        for (int i = 0; i <= nbits; i++) begin
            rx = f[i];
            repeat (OVS) @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_bits(input int n);
        if (n > GAP_BITS) model_gap();
        rx = 1'b1;
        repeat (n * OVS) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        rx    = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero_outputs(input string tag);
        checkOutput({tag, "_wr_en"},     int'(wr.wr_en),     0);
        checkOutput({tag, "_pkt_done"},  int'(wr.pkt_done),  0);
        checkOutput({tag, "_frame_err"}, int'(wr.frame_err), 0);
        checkOutput({tag, "_wr_addr"},   int'(wr.wr_addr),   0);
        checkOutput({tag, "_wr_data"},   int'(wr.wr_data),   0);
        checkOutput({tag, "_cycle"},     int'(wr.cycle),     0);
    endtask

    task automatic check_last4(input string name, input int base,
                               input int d0, input int d1, input int d2, input int d3);
        int n, d[4];
        d = '{d0, d1, d2, d3};
        n = log_addr.size();
        checkOutput({name, "_count"}, int'(n >= 4), 1);
        if (n >= 4) begin
            for (int i = 0; i < 4; i++) begin
                checkOutput($sformatf("%s_addr%0d", name, i), log_addr[n - 4 + i], base + i);
                checkOutput($sformatf("%s_data%0d", name, i), log_data[n - 4 + i], d[i]);
            end
        end
    endtask

    task automatic phase_end(input string name);
        idle_bits(2);
        checkOutput({name, "_writes_left"}, exp_q.size(), 0);
        checkOutput({name, "_errs_left"}, exp_err, 0);
    endtask

    // Per-cycle scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        wr_exp_t e;
        cyc_no++;
        if (reset) begin
            if (wr.wr_en) begin
                n_wr++;
                last_wr_cyc = cyc_no;
                log_addr.push_back(int'(wr.wr_addr));
                log_data.push_back(int'(wr.wr_data));
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_wr_en", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("wr_addr", int'(wr.wr_addr), e.addr);
                    checkOutput("wr_data", int'(wr.wr_data), e.data);
                    checkOutput("pkt_done", int'(wr.pkt_done), int'(e.last));
                    exp_addr = e.addr;
                    exp_data = e.data;
                    exp_cyc  = e.cyc_after;
                end
            end else begin
                checkOutput("pkt_done_no_wr", int'(wr.pkt_done), 0);
                checkOutput("wr_addr_hold", int'(wr.wr_addr), exp_addr);
                checkOutput("wr_data_hold", int'(wr.wr_data), exp_data);
            end
            checkOutput("cycle", int'(wr.cycle), exp_cyc);
            if (wr.frame_err) begin
                n_err++;
                last_err_cyc = cyc_no;
                checkOutput("frame_err_expected", int'(exp_err > 0), 1);
                if (exp_err > 0) exp_err--;
            end
            checkOutput("wr_en_one_cycle", int'(prev_wr && wr.wr_en), 0);
            checkOutput("pkt_done_one_cycle", int'(prev_done && wr.pkt_done), 0);
            checkOutput("frame_err_one_cycle", int'(prev_err && wr.frame_err), 0);
            prev_wr   = wr.wr_en;
            prev_done = wr.pkt_done;
            prev_err  = wr.frame_err;
        end else begin
            prev_wr = 0; prev_done = 0; prev_err = 0;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int s_wr, s_err, target;

        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        reset = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus(8'hA5, 1'b1);
        applyStimulus(8'h3C, 1'b1);
        applyStimulus(8'h01, 1'b1);
        applyStimulus(8'hFF, 1'b1);
        idle_bits(2);
        check_last4("pkt1", 0, 'hA5, 'h3C, 'h01, 'hFF);
        checkOutput("pkt1_cycle", int'(wr.cycle), 1);
        checkOutput("model_pkt1_cycle", m_cyc, 1);
        phase_end("pkt1");

        s_err = n_err;
        applyStimulus(8'h11, 1'b1);
        applyStimulus(8'h22, 1'b0);
        idle_bits(1);
        applyStimulus(8'h5A, 1'b1);
        applyStimulus(8'hC3, 1'b1);
        applyStimulus(8'h7E, 1'b1);
        applyStimulus(8'h81, 1'b1);
        phase_end("badstop");
        checkOutput("badstop_err_count", n_err - s_err, 1);
        check_last4("badstop_pkt", 4, 'h5A, 'hC3, 'h7E, 'h81);
        checkOutput("badstop_cycle", int'(wr.cycle), 2);

        applyStimulus(8'h12, 1'b1);
        applyStimulus(8'h34, 1'b1);
        idle_bits(13);
        checkOutput("gap_timing", last_err_cyc - last_wr_cyc, GAP_CYC);
        checkOutput("gap_cycle_kept", int'(wr.cycle), 2);
        applyStimulus(8'h56, 1'b1);
        applyStimulus(8'h78, 1'b1);
        applyStimulus(8'h9A, 1'b1);
        applyStimulus(8'hBC, 1'b1);
        phase_end("gap");
        check_last4("gap_pkt", 8, 'h56, 'h78, 'h9A, 'hBC);

        s_wr = n_wr; s_err = n_err;
        rx = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rx = 1'b1;
        idle_bits(2);
        checkOutput("glitch_no_wr", n_wr - s_wr, 0);
        checkOutput("glitch_no_err", n_err - s_err, 0);
        checkOutput("glitch_fsm_idle", int'(dut.u_bit.state == ST_IDLE), 1);

        // Start edge lands on the cycle the gap limit is reached.
        s_err = n_err;
        applyStimulus(8'h44, 1'b1);
        target = last_wr_cyc + GAP_CYC - 4;
        for (int k = 0; k < 400 && cyc_no != target; k++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("gap_race_align", cyc_no, target);
        model_gap();
        applyStimulus(8'h66, 1'b1);
        checkOutput("gap_race_err", n_err - s_err, 1);
        checkOutput("gap_race_addr", log_addr[$], 12);
        applyStimulus(8'h77, 1'b1);

        send_partial(8'hF0, 4);
        #2;
        reset = 1'b0;
        rx    = 1'b1;
        model_reset();
        #1;
        check_zero_outputs("async_reset");
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(8'hDE, 1'b1);
        applyStimulus(8'hAD, 1'b1);
        applyStimulus(8'hBE, 1'b1);
        applyStimulus(8'hEF, 1'b1);
        phase_end("post_reset");
        check_last4("post_reset_pkt", 0, 'hDE, 'hAD, 'hBE, 'hEF);
        checkOutput("post_reset_cycle", int'(wr.cycle), 1);

        s_err = n_err;
        model_byte(0, 1'b0);
        rx = 1'b0;
        repeat (30 * OVS) @(posedge clk);
        #1;
        idle_bits(2);
        checkOutput("break_err_once", n_err - s_err, 1);
        applyStimulus(8'hE7, 1'b1);
        checkOutput("break_next_addr", log_addr[$], 4);
        idle_bits(13);
        phase_end("break");

        do_reset();
        for (int p = 0; p < 32; p++) begin
            for (int i = 0; i < BYTES; i++) begin
                applyStimulus(8'((p * 37 + i * 11 + 5) & 'hFF), 1'b1);
            end
        end
        idle_bits(1);
        checkOutput("wrap32_cycle", int'(wr.cycle), 0);
        checkOutput("model_wrap32_cycle", m_cyc, 0);
        applyStimulus(8'h0F, 1'b1);
        applyStimulus(8'hF0, 1'b1);
        applyStimulus(8'h55, 1'b1);
        applyStimulus(8'hAA, 1'b1);
        phase_end("wrap");
        check_last4("pkt33", 0, 'h0F, 'hF0, 'h55, 'hAA);
        checkOutput("pkt33_cycle", int'(wr.cycle), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
